mem_arbiter: RTL and testbench

Shares the CPU's single memory/IO port between the CPU data path (load/store, IOR/IOW driven by the control unit) and an external DMA requester. It is a three-state FSM with fixed CPU priority, an anti-starvation counter for DMA, and a wait-state counter for slow IO accesses. It sits between the CPU core (`cpu_*`), the DMA engine (`dma_*`) and the memory/IO bus (`mem_*`). It stalls the CPU while the port is busy.

---
 rtl/mycpu_pkg.sv | 12 +
 rtl/arb_wait_cnt.sv | 32 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared types for the CPU memory-port arbiter.
//   arb_state_t : arbiter FSM states
//   ARB_CNT_W   : width of the wait-state and CPU-run counters
package mycpu_pkg;
    localparam int ARB_CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_t;
endpackage

// File: rtl/arb_wait_cnt.sv
// Loadable down-counter with zero flag, used to stretch slow IO accesses.
//   clk, rst_n  : clock, async active-low reset
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement, stops at zero
//   o_cnt       : current count
//   o_zero      : count == 0
module arb_wait_cnt
    import mycpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [ARB_CNT_W-1:0] i_load_val,
    input  logic                 i_dec,
    output logic [ARB_CNT_W-1:0] o_cnt,
    output logic                 o_zero
);
    logic [ARB_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - ARB_CNT_W'(1);
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory/IO port between the CPU data path and a DMA
// requester. Fixed CPU priority, with a run counter that forces a DMA grant
// after MAX_CPU_RUN back-to-back CPU grants while DMA waits. IO accesses by
// the CPU are stretched by IO_WAIT wait cycles.
//   clk, rst_n           : clock, async active-low reset
//   cpu_req/wen/iom/addr/wdata -> cpu_rdata, cpu_done, cpu_stall
//   dma_req/wen/addr/wdata     -> dma_rdata, dma_gnt, dma_done
//   mem_addr/wdata/wen/iom     -> bus; mem_rdata <- combinational read data
module mem_arbiter
    import mycpu_pkg::*;
#(
    parameter int IO_WAIT     = 2,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_wen,
    input  logic        cpu_iom,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wen,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_gnt,
    output logic        dma_done,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wen,
    output logic        mem_iom,
    input  logic [15:0] mem_rdata
);
    localparam logic [ARB_CNT_W-1:0] LP_IO_WAIT = ARB_CNT_W'(IO_WAIT);
    localparam logic [ARB_CNT_W-1:0] LP_MAX_RUN = ARB_CNT_W'(MAX_CPU_RUN);

    arb_state_t           r_state;
    logic [ARB_CNT_W-1:0] r_run_cnt;
    logic                 r_cpu_done;
    logic                 r_dma_done;
    logic                 r_dma_gnt;

    logic                 w_idle;
    logic                 w_cpu_win;
    logic                 w_load;
    logic [ARB_CNT_W-1:0] w_load_val;
    logic                 w_dec;
    logic [ARB_CNT_W-1:0] w_wait_cnt;
    logic                 w_wait_zero;
    logic                 w_wait_one;

    assign w_idle     = (r_state == ARB_IDLE);
    // CPU wins unless DMA is waiting and the CPU has used up its run budget.
    assign w_cpu_win  = cpu_req & (~dma_req | (r_run_cnt != LP_MAX_RUN));
    assign w_load     = w_idle & (cpu_req | dma_req);
    assign w_load_val = (w_cpu_win & cpu_iom) ? LP_IO_WAIT : '0;
    assign w_dec      = ~w_idle & ~w_wait_zero;
    assign w_wait_one = (w_wait_cnt == ARB_CNT_W'(1));

    arb_wait_cnt u_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_cnt      (w_wait_cnt),
        .o_zero     (w_wait_zero)
    );

    // Done flags are registered one cycle ahead: they are set on the edge
    // that enters the final access cycle (load of 0, or count going 1 -> 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_run_cnt  <= '0;
            r_cpu_done <= 1'b0;
            r_dma_done <= 1'b0;
            r_dma_gnt  <= 1'b0;
        end else begin
            r_cpu_done <= 1'b0;
            r_dma_done <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_cpu_win) begin
                        r_state    <= ARB_CPU;
                        r_cpu_done <= (w_load_val == '0);
                        if (!dma_req)
                            r_run_cnt <= '0;
                        else if (r_run_cnt != LP_MAX_RUN)
                            r_run_cnt <= r_run_cnt + ARB_CNT_W'(1);
                    end else if (dma_req) begin
                        r_state    <= ARB_DMA;
                        r_dma_gnt  <= 1'b1;
                        r_dma_done <= 1'b1;
                        r_run_cnt  <= '0;
                    end else begin
                        r_run_cnt <= '0;
                    end
                end
                ARB_CPU: begin
                    if (w_wait_zero)
                        r_state <= ARB_IDLE;
                    else if (w_wait_one)
                        r_cpu_done <= 1'b1;
                end
                ARB_DMA: begin
                    if (w_wait_zero) begin
                        r_state   <= ARB_IDLE;
                        r_dma_gnt <= 1'b0;
                    end else if (w_wait_one) begin
                        r_dma_done <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_dma_gnt <= 1'b0;
                end
            endcase
        end
    end

    // Bus follows the granted requester's live signals; the write strobe
    // only opens in the final cycle, which is exactly when done is high.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b1;
        mem_iom   = 1'b0;
        case (r_state)
            ARB_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_iom   = cpu_iom;
                mem_wen   = r_cpu_done ? cpu_wen : 1'b1;
            end
            ARB_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_wen   = r_dma_done ? dma_wen : 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_done  = r_cpu_done;
    assign dma_done  = r_dma_done;
    assign dma_gnt   = r_dma_gnt;
    assign cpu_rdata = r_cpu_done ? mem_rdata : '0;
    assign dma_rdata = r_dma_done ? mem_rdata : '0;
    // Gated by reset so the stall reads low while the core is held in reset.
    assign cpu_stall = cpu_req & ~r_cpu_done & rst_n;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (IO_WAIT=2, MAX_CPU_RUN=4).
module tb_mem_arbiter;
    import mycpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_wen, cpu_iom;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_stall;
    logic        dma_req, dma_wen;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_done;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen, mem_iom;

    int total = 0;
    int bad   = 0;
    int k;

    always #5 clk = ~clk;

    mem_arbiter #(.IO_WAIT(2), .MAX_CPU_RUN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_iom(cpu_iom),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wen(dma_wen), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_iom(mem_iom), .mem_rdata(mem_rdata)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start of a cycle: just past the rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic chk_bus_idle(input string tag);
        chk16({tag, "_addr"},  mem_addr,  16'h0000);
        chk16({tag, "_wdata"}, mem_wdata, 16'h0000);
        chk1 ({tag, "_wen"},   mem_wen,   1'b1);
        chk1 ({tag, "_iom"},   mem_iom,   1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_wen = 1; cpu_iom = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_wen = 1; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0;

        // Reset values
        cyc(); cyc();
        chk_bus_idle("rst");
        chk1 ("rst_cpu_done", cpu_done, 1'b0);
        chk1 ("rst_dma_done", dma_done, 1'b0);
        chk1 ("rst_dma_gnt",  dma_gnt,  1'b0);
        chk1 ("rst_stall",    cpu_stall, 1'b0);
        chk16("rst_cpu_rdata", cpu_rdata, 16'h0);
        chk16("rst_dma_rdata", dma_rdata, 16'h0);
        chk16("rst_state", 16'(dut.r_state), 16'(ARB_IDLE));
        rst_n = 1'b1;
        cyc();

        // CPU memory read 0x0010 -> 0xBEEF, done at N+1
        cpu_req = 1; cpu_wen = 1; cpu_iom = 0; cpu_addr = 16'h0010;
        mem_rdata = 16'hBEEF;
        settle();
        chk1("rd_stall_N", cpu_stall, 1'b1);
        chk1("rd_done_N",  cpu_done,  1'b0);
        chk_bus_idle("rd_idle_N");
        cyc();
        chk1 ("rd_done_N1",  cpu_done,  1'b1);
        chk16("rd_rdata_N1", cpu_rdata, 16'hBEEF);
        chk1 ("rd_stall_N1", cpu_stall, 1'b0);
        chk16("rd_addr_N1",  mem_addr,  16'h0010);
        chk1 ("rd_wen_N1",   mem_wen,   1'b1);
        chk16("rd_dma_rdata", dma_rdata, 16'h0);
        cpu_req = 0;
        cyc();
        chk1 ("rd_done_N2",  cpu_done,  1'b0);
        chk16("rd_rdata_N2", cpu_rdata, 16'h0);
        chk_bus_idle("rd_idle_N2");

        // CPU IO write 0x0003 <- 0x1234, three ARB_CPU cycles, strobe in the third
        cpu_req = 1; cpu_wen = 0; cpu_iom = 1; cpu_addr = 16'h0003; cpu_wdata = 16'h1234;
        settle();
        chk1("iow_stall_N", cpu_stall, 1'b1);
        cyc();
        chk16("iow_addr_N1",  mem_addr,  16'h0003);
        chk16("iow_wdata_N1", mem_wdata, 16'h1234);
        chk1 ("iow_iom_N1",   mem_iom,   1'b1);
        chk1 ("iow_wen_N1",   mem_wen,   1'b1);
        chk1 ("iow_done_N1",  cpu_done,  1'b0);
        chk1 ("iow_stall_N1", cpu_stall, 1'b1);
        cyc();
        chk16("iow_state_N2", 16'(dut.r_state), 16'(ARB_CPU));
        chk1 ("iow_wen_N2",  mem_wen,  1'b1);
        chk1 ("iow_done_N2", cpu_done, 1'b0);
        cyc();
        chk1("iow_wen_N3",   mem_wen,   1'b0);
        chk1("iow_done_N3",  cpu_done,  1'b1);
        chk1("iow_stall_N3", cpu_stall, 1'b0);
        cpu_req = 0;
        cyc();
        chk1("iow_done_N4", cpu_done, 1'b0);
        chk_bus_idle("iow_idle_N4");

        // DMA write alone 0x0100 <- 0x00FF
        mem_rdata = 16'h5A5A;
        dma_req = 1; dma_wen = 0; dma_addr = 16'h0100; dma_wdata = 16'h00FF;
        settle();
        chk1("dw_gnt_N", dma_gnt, 1'b0);
        cyc();
        chk1 ("dw_gnt_N1",   dma_gnt,   1'b1);
        chk1 ("dw_done_N1",  dma_done,  1'b1);
        chk1 ("dw_wen_N1",   mem_wen,   1'b0);
        chk16("dw_addr_N1",  mem_addr,  16'h0100);
        chk16("dw_wdata_N1", mem_wdata, 16'h00FF);
        chk1 ("dw_iom_N1",   mem_iom,   1'b0);
        chk16("dw_rdata_N1", dma_rdata, 16'h5A5A);
        chk16("dw_cpu_rdata", cpu_rdata, 16'h0);
        dma_req = 0;
        cyc();
        chk1 ("dw_gnt_N2",  dma_gnt,  1'b0);
        chk1 ("dw_done_N2", dma_done, 1'b0);
        chk16("dw_rdata_N2", dma_rdata, 16'h0);

        // Both requesting continuously: CPU x4 then DMA, repeating
        cpu_req = 1; cpu_wen = 1; cpu_iom = 0; cpu_addr = 16'h0020;
        dma_req = 1; dma_wen = 1; dma_addr = 16'h0040;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (cpu_done || dma_done) begin
                chk1("arb_order", dma_done, (k % 5) == 4);
                chk1("arb_excl",  cpu_done & dma_done, 1'b0);
                chk1("arb_gnt",   dma_gnt, dma_done);
                chk16("arb_addr", mem_addr, dma_done ? 16'h0040 : 16'h0020);
                k++;
            end
        end
        chk16("arb_ngrants", 16'(k), 16'd10);
        cpu_req = 0; dma_req = 0;
        cyc();

        // Reset during the second wait cycle of a CPU IO write
        cpu_req = 1; cpu_wen = 0; cpu_iom = 1; cpu_addr = 16'h0003; cpu_wdata = 16'h1234;
        cyc();
        chk1("rw_wen_w1", mem_wen, 1'b1);
        cyc();
        chk1("rw_wen_w2", mem_wen, 1'b1);
        rst_n = 1'b0;
        settle();
        chk_bus_idle("rw_rst");
        chk1 ("rw_done",  cpu_done,  1'b0);
        chk1 ("rw_stall", cpu_stall, 1'b0);
        chk1 ("rw_gnt",   dma_gnt,   1'b0);
        chk16("rw_rdata", cpu_rdata, 16'h0);
        cyc();
        chk1("rw_wen_hold", mem_wen,  1'b1);
        chk1("rw_done_hold", cpu_done, 1'b0);
        cpu_req = 0;
        rst_n = 1'b1;
        settle();
        chk16("rw_state_rel", 16'(dut.r_state), 16'(ARB_IDLE));
        cyc();
        chk16("rw_state_rel1", 16'(dut.r_state), 16'(ARB_IDLE));
        chk1 ("rw_wen_rel1", mem_wen,  1'b1);
        chk1 ("rw_done_rel1", cpu_done, 1'b0);

        // cpu_req dropped mid IO read: access completes, then stays idle
        cpu_req = 1; cpu_wen = 1; cpu_iom = 1; cpu_addr = 16'h0005;
        mem_rdata = 16'h7777;
        cyc();
        chk16("drop_state_N1", 16'(dut.r_state), 16'(ARB_CPU));
        cpu_req = 0;
        settle();
        chk1("drop_stall_N1", cpu_stall, 1'b0);
        cyc();
        chk1 ("drop_done_N2", cpu_done, 1'b0);
        chk16("drop_state_N2", 16'(dut.r_state), 16'(ARB_CPU));
        cyc();
        chk1 ("drop_done_N3",  cpu_done,  1'b1);
        chk16("drop_rdata_N3", cpu_rdata, 16'h7777);
        chk16("drop_addr_N3",  mem_addr,  16'h0005);
        cyc();
        chk16("drop_state_N4", 16'(dut.r_state), 16'(ARB_IDLE));
        chk_bus_idle("drop_idle_N4");
        cyc();
        chk16("drop_state_N5", 16'(dut.r_state), 16'(ARB_IDLE));
        chk1 ("drop_done_N5", cpu_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
